// File: rtl/ps_mem_pkg.sv
// Shared types and constants for the processor memory responder.
// State encoding and the instruction returned when the core reads IM outside RUN.
package ps_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] NOP_INSTR = 16'hF000;

  // A core access is only legal in RUN; an instruction fetch is also tolerated in START
  // because the core may begin prefetching on the start pulse.
  function automatic logic core_access_err(state_t s, logic im_rd, logic dm_rd, logic dm_wr);
    return ((dm_rd || dm_wr) && (s != S_RUN)) ||
           (im_rd && (s != S_RUN) && (s != S_START));
  endfunction

endpackage

// File: rtl/ps_mem_responder_if.sv
// Loader stream plus core IM/DM bus of the processor memory responder.
// master = loader/core side, slave = responder side.
interface ps_mem_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  ld_valid;
  logic                  ld_ready;
  logic                  ld_sel;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_last;
  logic                  start_o;
  logic                  stop_i;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic                  im_rd;
  logic [DATA_WIDTH-1:0] im_r_data;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic                  dm_rd;
  logic                  dm_wr;
  logic [DATA_WIDTH-1:0] dm_w_data;
  logic [DATA_WIDTH-1:0] dm_r_data;

  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data, ld_last, stop_i,
           im_addr, im_rd, dm_addr, dm_rd, dm_wr, dm_w_data,
    input  ld_ready, start_o, im_r_data, dm_r_data
  );

  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data, ld_last, stop_i,
           im_addr, im_rd, dm_addr, dm_rd, dm_wr, dm_w_data,
    output ld_ready, start_o, im_r_data, dm_r_data
  );
endinterface

// File: rtl/mem_bank.sv
// Word memory with one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset so they survive a responder reset.
module mem_bank #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Store the write word at the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ps_mem_responder.sv
// Responder side of the processor IM/DM interface: loader FSM fills IM/DM from a
// valid/ready stream, pulses start_o, serves the core during RUN and counts run cycles.
// Optional macro PS_MEM_RDW_BYPASS_EN: a same-cycle DM read and write returns the write word.
module ps_mem_responder
  import ps_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  ps_mem_responder_if.slave    bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] cyc_cnt_o
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_cyc_cnt;
  logic                  w_ld_we;
  logic                  w_im_we;
  logic                  w_core_we;
  logic                  w_dm_we;
  logic [ADDR_WIDTH-1:0] w_dm_waddr;
  logic [DATA_WIDTH-1:0] w_dm_wdata;
  logic [DATA_WIDTH-1:0] w_im_rdata;
  logic [DATA_WIDTH-1:0] w_dm_rdata;

  // State register; reset returns to IDLE on the next edge.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: load, one start cycle, run until stop, reload from DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.ld_valid) w_next = S_LOAD;
      S_LOAD:  if (bus.ld_valid && bus.ld_last) w_next = S_START;
      S_START: w_next = S_RUN;
      S_RUN:   if (bus.stop_i) w_next = S_DONE;
      S_DONE:  if (bus.ld_valid) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    bus.ld_ready = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DONE);
    bus.start_o  = (r_state == S_START);
    busy_o       = (r_state == S_LOAD) || (r_state == S_START) || (r_state == S_RUN);
    done_o       = (r_state == S_DONE);
  end

  // A write presented in the same cycle as reset is dropped.
  assign w_ld_we   = bus.ld_valid && bus.ld_ready && !rst;
  assign w_im_we   = w_ld_we && !bus.ld_sel;
  assign w_core_we = (r_state == S_RUN) && bus.dm_wr && !rst;

  // DM write port is shared: loader beats and core writes never coincide in the same state.
  always_comb begin
    w_dm_we    = w_core_we;
    w_dm_waddr = bus.dm_addr;
    w_dm_wdata = bus.dm_w_data;
    if (w_ld_we && bus.ld_sel) begin
      w_dm_we    = 1'b1;
      w_dm_waddr = bus.ld_addr;
      w_dm_wdata = bus.ld_data;
    end
  end

  mem_bank #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_im (
    .clk     (clk),
    .i_we    (w_im_we),
    .i_waddr (bus.ld_addr),
    .i_wdata (bus.ld_data),
    .i_raddr (bus.im_addr),
    .o_rdata (w_im_rdata)
  );

  mem_bank #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_dm (
    .clk     (clk),
    .i_we    (w_dm_we),
    .i_waddr (w_dm_waddr),
    .i_wdata (w_dm_wdata),
    .i_raddr (bus.dm_addr),
    .o_rdata (w_dm_rdata)
  );

  // Read data is only exposed in RUN; otherwise IM returns a NOP and DM returns zero.
  always_comb begin
    bus.im_r_data = DATA_WIDTH'(NOP_INSTR);
    bus.dm_r_data = '0;
    if ((r_state == S_RUN) && bus.im_rd) bus.im_r_data = w_im_rdata;
    if ((r_state == S_RUN) && bus.dm_rd) begin
`ifdef PS_MEM_RDW_BYPASS_EN
      bus.dm_r_data = bus.dm_wr ? bus.dm_w_data : w_dm_rdata;
`else
      bus.dm_r_data = w_dm_rdata;
`endif
    end
  end

  // Sticky error on illegal core access or a loader beat while the loader is not ready.
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else if (core_access_err(r_state, bus.im_rd, bus.dm_rd, bus.dm_wr) ||
             (bus.ld_valid && !bus.ld_ready))
      r_err <= 1'b1;
  end

  // Run-cycle counter: saturating in RUN, held in DONE, cleared when a reload begins.
  always_ff @(posedge clk) begin
    if (rst) r_cyc_cnt <= '0;
    else if ((r_state == S_RUN) && (r_cyc_cnt != '1))
      r_cyc_cnt <= r_cyc_cnt + CNT_WIDTH'(1);
    else if ((r_state == S_DONE) && bus.ld_valid)
      r_cyc_cnt <= '0;
  end

  assign err_o     = r_err;
  assign cyc_cnt_o = r_cyc_cnt;

endmodule
